// File: rtl/univ_shift_register.sv
// univ_shift_register: universal shift register with per-cycle mode select
// and a start-triggered serializer burst that shifts a word out MSB-first.
module univ_shift_register #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ROL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  // Counter value on the edge that performs the final burst shift.
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_t        state;
  logic [CW-1:0] count;

  // Serial taps come straight off the register ends.
  assign sout_l = out[WIDTH-1];
  assign sout_r = out[0];

  // Register, burst FSM, counter and status flags; start outranks mode in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      state <= IDLE;
      count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            out   <= load_data;
            count <= '0;
            state <= SHIFT;
            busy  <= 1'b1;
          end else if (en) begin
            case (mode)
              MODE_HOLD:  out <= out;
              MODE_SHL:   out <= {out[WIDTH-2:0], sin_l};
              MODE_SHR:   out <= {sin_r, out[WIDTH-1:1]};
              MODE_ROL:   out <= {out[WIDTH-2:0], out[WIDTH-1]};
              MODE_ROR:   out <= {out[0], out[WIDTH-1:1]};
              MODE_LOAD:  out <= load_data;
              MODE_ASR:   out <= {out[WIDTH-1], out[WIDTH-1:1]};
              MODE_CLEAR: out <= '0;
              default:    out <= out;
            endcase
          end
        end
        SHIFT: begin
          if (en) begin
            out   <= {out[WIDTH-2:0], sin_l};
            count <= count + 1'b1;
            if (count == LAST_COUNT) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_register.sv
// tb_univ_shift_register: table-driven mode checks plus hand-written burst,
// pause, reset and back-to-back sequences for the 8-bit configuration.
module tb_univ_shift_register;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] load_data;
  logic       start;
  logic [7:0] out;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       en;
    logic [2:0] mode;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] load;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs [15];

  univ_shift_register #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .load_data (load_data),
    .start     (start),
    .out       (out),
    .sout_l    (sout_l),
    .sout_r    (sout_r),
    .busy      (busy),
    .done      (done)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic e, input logic [2:0] m, input logic sl,
                               input logic sr, input logic [7:0] ld, input logic st);
    en        = e;
    mode      = m;
    sin_l     = sl;
    sin_r     = sr;
    load_data = ld;
    start     = st;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one burst from the start cycle through the done cycle, tracking a
  // reference shift register; optionally pauses and drives ignored inputs.
  task automatic runBurst(input string tag, input logic [7:0] data, input logic sin,
                          input int pause_at, input int pause_len, input bit junk,
                          input int exp_busy);
    logic [7:0] model;
    int k;
    int paused;
    int busy_cycles;
    int guard;
    applyStimulus(1'b1, 3'b000, sin, 1'b0, data, 1'b1);
    stepCycle();
    model       = data;
    k           = 0;
    paused      = 0;
    busy_cycles = 0;
    guard       = 0;
    while (k < 8 && guard < 40) begin
      checkOutput({tag, "_out"}, out, model);
      checkOutput({tag, "_sout_l"}, {7'b0, sout_l}, {7'b0, data[7-k]});
      checkOutput({tag, "_done_low"}, {7'b0, done}, 8'h00);
      if (busy) busy_cycles++;
      if (k == pause_at && paused < pause_len) begin
        en = 1'b0;
        paused++;
      end else begin
        en    = 1'b1;
        model = {model[6:0], sin};
        k++;
      end
      start     = junk ? guard[0] : 1'b0;
      mode      = junk ? 3'b111 : 3'b000;
      load_data = junk ? 8'hFF : data;
      stepCycle();
      guard++;
    end
    if (guard >= 40) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d cycles expected burst to end", tag, guard);
    end
    checkOutput({tag, "_busy_cycles"}, 8'(busy_cycles), 8'(exp_busy));
    checkOutput({tag, "_busy_end"}, {7'b0, busy}, 8'h00);
    checkOutput({tag, "_done_pulse"}, {7'b0, done}, 8'h01);
    checkOutput({tag, "_final_out"}, out, model);
    start = 1'b0;
    mode  = 3'b000;
    en    = 1'b1;
  endtask

  initial begin
    // Mode vectors applied from a known zero register, one per cycle.
    vecs[0]  = '{1'b1, 3'b101, 1'b0, 1'b0, 8'h96, 8'h96};
    vecs[1]  = '{1'b1, 3'b011, 1'b0, 1'b0, 8'h00, 8'h2D};
    vecs[2]  = '{1'b1, 3'b100, 1'b0, 1'b0, 8'h00, 8'h96};
    vecs[3]  = '{1'b1, 3'b001, 1'b1, 1'b0, 8'h00, 8'h2D};
    vecs[4]  = '{1'b1, 3'b101, 1'b0, 1'b0, 8'h96, 8'h96};
    vecs[5]  = '{1'b1, 3'b110, 1'b0, 1'b0, 8'h00, 8'hCB};
    vecs[6]  = '{1'b1, 3'b010, 1'b0, 1'b0, 8'h00, 8'h65};
    vecs[7]  = '{1'b1, 3'b111, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 3'b101, 1'b0, 1'b0, 8'h3C, 8'h3C};
    vecs[9]  = '{1'b0, 3'b001, 1'b1, 1'b0, 8'h00, 8'h3C};
    vecs[10] = '{1'b1, 3'b000, 1'b1, 1'b1, 8'hFF, 8'h3C};
    vecs[11] = '{1'b1, 3'b010, 1'b0, 1'b1, 8'h00, 8'h9E};
    vecs[12] = '{1'b1, 3'b110, 1'b0, 1'b0, 8'h00, 8'hCF};
    vecs[13] = '{1'b1, 3'b001, 1'b0, 1'b0, 8'h00, 8'h9E};
    vecs[14] = '{1'b0, 3'b111, 1'b0, 1'b0, 8'h00, 8'h9E};

    // Reset held for 5 cycles while a load is requested.
    reset = 1'b1;
    applyStimulus(1'b1, 3'b101, 1'b0, 1'b0, 8'hA5, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("reset_out", out, 8'h00);
      checkOutput("reset_busy", {7'b0, busy}, 8'h00);
      checkOutput("reset_done", {7'b0, done}, 8'h00);
      stepCycle();
    end
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    stepCycle();
    checkOutput("post_reset_out", out, 8'h00);

    // Table-driven mode operations.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].en, vecs[i].mode, vecs[i].sin_l, vecs[i].sin_r, vecs[i].load, 1'b0);
      stepCycle();
      checkOutput($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      checkOutput($sformatf("vec%0d_sout_r", i), {7'b0, sout_r}, {7'b0, vecs[i].exp_out[0]});
      checkOutput($sformatf("vec%0d_busy", i), {7'b0, busy}, 8'h00);
      checkOutput($sformatf("vec%0d_done", i), {7'b0, done}, 8'h00);
    end

    // Asynchronous reset mid-cycle clears the register with no clock edge.
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_out", out, 8'h00);
    stepCycle();
    reset = 1'b0;
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0);
    stepCycle();

    // Plain burst of 8'hB4 with sin_l = 0.
    runBurst("burst", 8'hB4, 1'b0, -1, 0, 1'b0, 8);
    stepCycle();
    checkOutput("burst_done_clear", {7'b0, done}, 8'h00);

    // Same burst with a 3-cycle pause after the 2nd bit and ignored inputs toggling.
    runBurst("pause", 8'hB4, 1'b0, 2, 3, 1'b1, 11);
    stepCycle();
    checkOutput("pause_done_clear", {7'b0, done}, 8'h00);

    // Reset after 4 shifts of a burst.
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 8'hB4, 1'b1);
    stepCycle();
    start = 1'b0;
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("midrst_before_out", out, 8'h40);
    checkOutput("midrst_before_busy", {7'b0, busy}, 8'h01);
    reset = 1'b1;
    #1;
    checkOutput("midrst_out", out, 8'h00);
    checkOutput("midrst_busy", {7'b0, busy}, 8'h00);
    stepCycle();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      checkOutput("midrst_no_done", {7'b0, done}, 8'h00);
      checkOutput("midrst_idle_busy", {7'b0, busy}, 8'h00);
    end
    runBurst("after_rst", 8'h69, 1'b1, -1, 0, 1'b0, 8);
    checkOutput("after_rst_ff", out, 8'hFF);

    // Back-to-back: the next start is driven in the done cycle.
    runBurst("b2b_first", 8'hC3, 1'b1, -1, 0, 1'b0, 8);
    runBurst("b2b_second", 8'h5A, 1'b0, -1, 0, 1'b0, 8);
    stepCycle();
    checkOutput("b2b_done_clear", {7'b0, done}, 8'h00);
    checkOutput("b2b_idle_busy", {7'b0, busy}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_register.md
# univ_shift_register

Parametrised universal shift register with a built-in serializer burst mode. It supports hold, logical and arithmetic shifts, rotates, parallel load and clear, selected per cycle by `mode`. A `start` pulse loads a word and automatically shifts it out MSB-first over WIDTH enabled cycles, with `busy` and `done` status. It replaces fixed-width left-only shift registers wherever the datapath needs serial/parallel conversion.

## Interface
- `WIDTH`, default 8: register width in bits. Legal range is WIDTH ≥ 2.
- `CW`, default `$clog2(WIDTH+1)`: width of the burst counter. Derived; do not override.
- `clk`  in  1: clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `en`  in  1: shift/operation enable. Applies in both IDLE and SHIFT.
- `mode`  in  3: operation select in IDLE. Ignored while `busy`.
- `sin_l`  in  1: serial input. Enters the LSB on left shifts, including burst shifts.
- `sin_r`  in  1: serial input. Enters the MSB on logical right shift.
- `load_data`  in  WIDTH: parallel load word. Used by mode 101 and by `start`.
- `start`  in  1: begin a serializer burst. Sampled only in IDLE.
- `out`  out  WIDTH: register contents (registered).
- `sout_l`  out  1: `out[WIDTH-1]` (combinational from the register).
- `sout_r`  out  1: `out[0]` (combinational from the register).
- `busy`  out  1: high while in the SHIFT state (registered).
- `done`  out  1: one-cycle pulse after the final burst shift (registered).

## Operation
- **Reset:** `out` = 0, `busy` = 0, `done` = 0, state = IDLE, counter = 0.
- **FSM states:** IDLE and SHIFT.
- **IDLE, `start` = 1:** this takes priority over `mode` and `en`.
  - `out` ← `load_data`, counter ← 0, state ← SHIFT.
- **IDLE, `start` = 0, `en` = 1:** apply `mode`.
  - 000: hold.
  - 001: shift left, `{out[W-2:0], sin_l}`.
  - 010: shift right, `{sin_r, out[W-1:1]}`.
  - 011: rotate left, `{out[W-2:0], out[W-1]}`.
  - 100: rotate right, `{out[0], out[W-1:1]}`.
  - 101: parallel load, `load_data`.
  - 110: arithmetic right shift, `{out[W-1], out[W-1:1]}`.
  - 111: clear to 0.
- **IDLE, `en` = 0:** hold, regardless of `mode`.
- **SHIFT, `en` = 1:**
  - `out` ← `{out[W-2:0], sin_l}`, counter ← counter + 1.
  - When counter == WIDTH-1 at this edge, state ← IDLE and `done` ← 1.
- **SHIFT, `en` = 0:** pause. `out` and counter hold; the burst resumes when `en` returns.
- **Ignored inputs in SHIFT:** `start` and `mode` have no effect.
- **`done`:** cleared on every edge where it is not being set.
- **Bit order:** during the k-th enabled SHIFT cycle (k = 0..WIDTH-1), `sout_l` = `load_data[WIDTH-1-k]`.
- **Register after a burst:** `out` holds the WIDTH `sin_l` bits shifted in, first-sampled in the MSB.
- **Reset mid-burst:** immediate return to the reset values. No `done` pulse is generated.

## Timing
- **Start to first serial bit:** `start` is sampled at edge E0. `busy` = 1 and `out` = `load_data` after E0, so `sout_l` shows the first bit in the cycle after E0.
- **Burst length:** with continuous `en`, the burst occupies exactly WIDTH cycles after E0.
  - `busy` falls and `done` rises after edge E0+WIDTH.
  - `done` is high for exactly one cycle.
- **Pauses:** each `en` = 0 cycle in SHIFT extends the burst by one cycle.
- **Back-to-back bursts:** a new `start` is accepted in the cycle where `done` = 1 (state is IDLE). Minimum burst period is WIDTH+1 cycles.
- **Mode operations:** single-cycle; the result is visible in `out` after the sampling edge.

## Test plan
- **Reset:** assert `reset` for 5 cycles with `mode` = 101 and `load_data` = 8'hA5 → `out` = 8'h00, `busy` = 0, `done` = 0 throughout. The async assert mid-cycle clears `out` without waiting for a clock edge.
- **Modes (WIDTH=8, `en` = 1):**
  - Load 8'h96, then rotate left → 8'h2D; rotate right → 8'h96.
  - Shift left with `sin_l` = 1 → 8'h2D.
  - Load 8'h96, arithmetic right shift → 8'hCB.
  - Shift right with `sin_r` = 0 → 8'h65.
  - Clear → 8'h00.
  - Mode 001 with `en` = 0 → holds.
- **Burst (WIDTH=8):** `start` with `load_data` = 8'hB4, `sin_l` = 0, `en` = 1 → `sout_l` sequence 1,0,1,1,0,1,0,0; `busy` high for 8 cycles; `done` pulses once in the 9th cycle; final `out` = 8'h00.
- **Pause and ignored inputs:** same burst, with `en` dropped for 3 cycles after the 2nd bit and `start`/`mode` = 111 toggled mid-burst → same bit sequence, `busy` lasts 11 cycles, `out` is never cleared.
- **Reset mid-burst:** pulse `reset` after 4 shifts → `out` = 0, `busy` = 0, no `done`. A following `start` runs a full 8-bit burst.
- **Back-to-back:** `start` asserted in the `done` cycle → the second burst begins immediately; bits are contiguous apart from one load cycle.
